// File: rtl/meas_sequencer_pkg.sv
// meas_sequencer shared definitions: state encoding,
// default phase lengths and counter widths.
package meas_seq_pkg;

    localparam int DEF_WINDOW = 100000;
    localparam int DEF_STRESS = 1000000;
    localparam int DEF_SETTLE = 4;
    localparam int DEF_TMR_W  = 32;
    localparam int CNT_W      = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_STRESS  = 3'd1;
    localparam state_t S_CLEAR   = 3'd2;
    localparam state_t S_WINDOW  = 3'd3;
    localparam state_t S_SETTLE  = 3'd4;
    localparam state_t S_CAPTURE = 3'd5;

endpackage

// File: rtl/meas_sequencer_if.sv
// Control/result bundle between the sequencer and the
// oscillator / counting datapath.
interface meas_sequencer_if #(
    parameter int VALUE_W = 16
);
    logic                           run;
    logic                           stress_en;
    logic                           alt_mode;
    logic [VALUE_W-1:0]             meas_value;
    logic                           osc_mode;
    logic                           osc_stress;
    logic                           meas_enable;
    logic                           meas_reset;
    logic [VALUE_W-1:0]             value_out;
    logic                           value_valid;
    logic                           busy;
    logic [meas_seq_pkg::CNT_W-1:0] sample_count;

    modport master (
        input  run, stress_en, alt_mode, meas_value,
        output osc_mode, osc_stress, meas_enable, meas_reset,
        output value_out, value_valid, busy, sample_count
    );

    modport slave (
        output run, stress_en, alt_mode, meas_value,
        input  osc_mode, osc_stress, meas_enable, meas_reset,
        input  value_out, value_valid, busy, sample_count
    );

endinterface

// File: rtl/meas_sequencer_phase_timer.sv
// Loadable down-counter; done_o is high while the count is zero.
module phase_timer #(
    parameter int TMR_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             done_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/meas_sequencer.sv
// Measurement sequencer: stress, clear, gate window, settle,
// then capture the datapath result into a held register.
module meas_sequencer
    import meas_seq_pkg::*;
#(
    parameter int VALUE_W       = 16,
    parameter int WINDOW_CYCLES = DEF_WINDOW,
    parameter int STRESS_CYCLES = DEF_STRESS,
    parameter int SETTLE_CYCLES = DEF_SETTLE,
    parameter int TMR_W         = DEF_TMR_W
) (
    input logic               fpga_clk1,
    input logic               reset,
    meas_sequencer_if.master  bus
);

    localparam logic [TMR_W-1:0] WIN_LD = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] STR_LD = TMR_W'(STRESS_CYCLES - 1);
    localparam logic [TMR_W-1:0] SET_LD = TMR_W'(SETTLE_CYCLES - 1);

    state_t             state_q;
    state_t             state_d;
    state_t             start_st;
    logic               tmr_load;
    logic               tmr_done;
    logic [TMR_W-1:0]   tmr_val;
    logic               cap;
    logic [VALUE_W-1:0] value_q;
    logic               valid_q;
    logic [CNT_W-1:0]   count_q;
    logic               mode_q;

    assign start_st = bus.stress_en ? S_STRESS : S_CLEAR;
    assign cap      = (state_q == S_CAPTURE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = start_st;
            end
            S_STRESS: begin
                if (!bus.run)     state_d = S_IDLE;
                else if (tmr_done) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = bus.run ? S_WINDOW : S_IDLE;
            end
            S_WINDOW: begin
                if (!bus.run)     state_d = S_IDLE;
                else if (tmr_done) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (!bus.run)     state_d = S_IDLE;
                else if (tmr_done) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = bus.run ? start_st : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Timer is reloaded with N-1 on every state change
    assign tmr_load = (state_d != state_q);

    always_comb begin
        tmr_val = '0;
        unique case (state_d)
            S_STRESS: tmr_val = STR_LD;
            S_WINDOW: tmr_val = WIN_LD;
            S_SETTLE: tmr_val = SET_LD;
            default:  tmr_val = '0;
        endcase
    end

    phase_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk_i      (fpga_clk1),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge fpga_clk1 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            value_q <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= cap;
            if (cap) begin
                value_q <= bus.meas_value;
                count_q <= count_q + CNT_W'(1);
                if (bus.alt_mode) mode_q <= ~mode_q;
            end
        end
    end

    assign bus.osc_mode     = mode_q;
    assign bus.osc_stress   = (state_q == S_STRESS);
    assign bus.meas_enable  = (state_q == S_WINDOW);
    assign bus.meas_reset   = (state_q == S_IDLE)
                            | (state_q == S_STRESS)
                            | (state_q == S_CLEAR);
    assign bus.value_out    = value_q;
    assign bus.value_valid  = valid_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.sample_count = count_q;

endmodule

// File: tb/tb_meas_sequencer.sv
// Directed bench for meas_sequencer with a capture scoreboard;
// instance b uses single-cycle phases for the wrap run.
module tb_meas_sequencer;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        logic [7:0]  cnt;
        logic        mode;
    } exp_t;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    exp_t qa[$];
    exp_t qb[$];

    meas_sequencer_if #(.VALUE_W(16)) ifa ();
    meas_sequencer_if #(.VALUE_W(16)) ifb ();

    meas_sequencer #(
        .VALUE_W       (16),
        .WINDOW_CYCLES (10),
        .STRESS_CYCLES (20),
        .SETTLE_CYCLES (4),
        .TMR_W         (16)
    ) dut_a (
        .fpga_clk1 (clk),
        .reset     (rst),
        .bus       (ifa)
    );

    meas_sequencer #(
        .VALUE_W       (16),
        .WINDOW_CYCLES (1),
        .STRESS_CYCLES (1),
        .SETTLE_CYCLES (1),
        .TMR_W         (8)
    ) dut_b (
        .fpga_clk1 (clk),
        .reset     (rst),
        .bus       (ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chkw(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag,
                        input logic obs,
                        input logic exp);
        chkw(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    task automatic push_a(input int c, input logic [15:0] v,
                          input logic [7:0] n, input logic m);
        qa.push_back(exp_t'{c, v, n, m});
    endtask

    task automatic push_b(input int c, input logic [15:0] v,
                          input logic [7:0] n, input logic m);
        qb.push_back(exp_t'{c, v, n, m});
    endtask

    task automatic mon();
        exp_t e;
        if (ifa.value_valid === 1'b1) begin
            chk1("vv_consec_a", prev_a, 1'b0);
            chk1("sb_pending_a", qa.size() != 0, 1'b1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chkw("vv_cycle_a", cyc, e.cyc);
                chkw("value_a", 32'(ifa.value_out), 32'(e.val));
                chkw("count_a", 32'(ifa.sample_count), 32'(e.cnt));
                chk1("mode_a", ifa.osc_mode, e.mode);
            end
        end
        if (ifb.value_valid === 1'b1) begin
            chk1("vv_consec_b", prev_b, 1'b0);
            chk1("sb_pending_b", qb.size() != 0, 1'b1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chkw("vv_cycle_b", cyc, e.cyc);
                chkw("value_b", 32'(ifb.value_out), 32'(e.val));
                chkw("count_b", 32'(ifb.sample_count), 32'(e.cnt));
            end
        end
        prev_a = ifa.value_valid;
        prev_b = ifb.value_valid;
    endtask

    task automatic step();
        @(negedge clk);
        mon();
    endtask

    task automatic chk_reset_a(input string tag);
        chk1({tag, "_mode"}, ifa.osc_mode, 1'b0);
        chk1({tag, "_stress"}, ifa.osc_stress, 1'b0);
        chk1({tag, "_en"}, ifa.meas_enable, 1'b0);
        chk1({tag, "_mrst"}, ifa.meas_reset, 1'b1);
        chk1({tag, "_vv"}, ifa.value_valid, 1'b0);
        chk1({tag, "_busy"}, ifa.busy, 1'b0);
        chkw({tag, "_val"}, 32'(ifa.value_out), 32'd0);
        chkw({tag, "_cnt"}, 32'(ifa.sample_count), 32'd0);
    endtask

    initial begin
        int t0;
        int p;
        ifa.run = 1'b0;
        ifa.stress_en = 1'b0;
        ifa.alt_mode = 1'b0;
        ifa.meas_value = 16'h0;
        ifb.run = 1'b0;
        ifb.stress_en = 1'b0;
        ifb.alt_mode = 1'b0;
        ifb.meas_value = 16'h0;

        repeat (3) step();
        chk_reset_a("rst");
        rst = 1'b0;
        step();
        chk_reset_a("idle");
        chkw("b_rst_cnt", 32'(ifb.sample_count), 32'd0);

        // Two back-to-back captures without stress
        ifa.meas_value = 16'h1234;
        ifa.run = 1'b1;
        t0 = cyc;
        push_a(t0 + 17, 16'h1234, 8'd1, 1'b0);
        push_a(t0 + 33, 16'h1234, 8'd2, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            step();
            p = (i - 1) % 16 + 1;
            chk1("win_en", ifa.meas_enable, (p >= 2) && (p <= 11));
            chk1("win_mrst", ifa.meas_reset, p == 1);
            chk1("win_busy", ifa.busy, 1'b1);
        end
        ifa.run = 1'b0;
        repeat (3) step();
        chk1("t1_idle", ifa.busy, 1'b0);
        chkw("t1_cnt", 32'(ifa.sample_count), 32'd2);

        // Abort in the fifth WINDOW cycle
        ifa.meas_value = 16'hBEEF;
        ifa.run = 1'b1;
        repeat (6) step();
        chk1("ab_en", ifa.meas_enable, 1'b1);
        ifa.run = 1'b0;
        step();
        chk1("ab_busy", ifa.busy, 1'b0);
        chk1("ab_en_off", ifa.meas_enable, 1'b0);
        chk1("ab_mrst", ifa.meas_reset, 1'b1);
        chkw("ab_val", 32'(ifa.value_out), 32'h1234);
        chkw("ab_cnt", 32'(ifa.sample_count), 32'd2);
        repeat (20) step();

        // Stress phase precedes the measurement
        ifa.meas_value = 16'h5A5A;
        ifa.stress_en = 1'b1;
        ifa.run = 1'b1;
        t0 = cyc;
        push_a(t0 + 37, 16'h5A5A, 8'd3, 1'b0);
        for (int i = 1; i <= 36; i++) begin
            step();
            chk1("st_stress", ifa.osc_stress, i <= 20);
            chk1("st_mrst", ifa.meas_reset, i <= 21);
            chk1("st_en", ifa.meas_enable, (i >= 22) && (i <= 31));
            if (i == 5) ifa.stress_en = 1'b0;
        end
        ifa.run = 1'b0;
        repeat (3) step();

        // Mode alternation over four captures
        ifa.meas_value = 16'hC3C3;
        ifa.alt_mode = 1'b1;
        ifa.run = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 4; k++)
            push_a(t0 + 17 + 16 * k, 16'hC3C3, 8'(4 + k),
                   (k % 2) == 0);
        for (int i = 1; i <= 64; i++) begin
            step();
            chk1("alt_mode", ifa.osc_mode, (((i - 1) / 16) % 2) == 1);
        end
        ifa.run = 1'b0;
        repeat (3) step();
        ifa.alt_mode = 1'b0;
        chkw("alt_cnt", 32'(ifa.sample_count), 32'd7);

        // Asynchronous reset in SETTLE
        ifa.meas_value = 16'h7777;
        ifa.run = 1'b1;
        repeat (13) step();
        chk1("pre_rst_en", ifa.meas_enable, 1'b0);
        chk1("pre_rst_mrst", ifa.meas_reset, 1'b0);
        chk1("pre_rst_busy", ifa.busy, 1'b1);
        #2 rst = 1'b1;
        #1 chk_reset_a("async");
        ifa.run = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        repeat (20) step();
        chk_reset_a("post_rst");

        // 256 captures with single-cycle phases
        ifb.meas_value = 16'h00A5;
        ifb.run = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 256; k++)
            push_b(t0 + 5 + 4 * k, 16'h00A5, 8'(k + 1), 1'b0);
        for (int i = 1; i <= 1024; i++) step();
        ifb.run = 1'b0;
        repeat (3) step();
        chkw("wrap_cnt", 32'(ifb.sample_count), 32'd0);
        chk1("wrap_busy", ifb.busy, 1'b0);

        chkw("sb_left_a", qa.size(), 32'd0);
        chkw("sb_left_b", qb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
